// File: rtl/audio_mixer.sv
// Four-channel priority tone mixer with activity timeout and PWM volume.
// Optional mute input enabled by defining AUDIO_MIXER_MUTE_EN.
module audio_mixer #(
  parameter int ACT_WINDOW = 100000,
  parameter int CNT_W      = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       win_snd,
  input  logic       water_snd,
  input  logic       car_snd,
  input  logic       hop_snd,
  input  logic [2:0] volume,
`ifdef AUDIO_MIXER_MUTE_EN
  input  logic       mute,
`endif
  output logic       speaker_out,
  output logic [1:0] active_ch,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  localparam logic [CNT_W-1:0] LOAD =
    CNT_W'(ACT_WINDOW);

  logic [3:0]       wave_d;
  logic [3:0]       wave_q;
  logic [3:0]       toggle;
  logic [3:0]       active;
  logic             armed;
  logic [CNT_W-1:0] cnt [4];
  state_t           state;
  state_t           state_nxt;
  logic [1:0]       owner;
  logic [1:0]       owner_nxt;
  logic [1:0]       top;
  logic [2:0]       pwm_cnt;
  logic             gate;
  logic             mute_s;
  logic             spk_nxt;

  assign wave_d = {win_snd, water_snd,
                   car_snd, hop_snd};

  // The first capture after reset only
  // primes wave_q, so a level held through
  // reset is not mistaken for a toggle.
  assign toggle = armed ?
                  (wave_d ^ wave_q) : 4'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_q <= 4'b0;
      armed  <= 1'b0;
    end else begin
      wave_q <= wave_d;
      armed  <= 1'b1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_act
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[i] <= '0;
      end else if (toggle[i]) begin
        cnt[i] <= LOAD;
      end else if (cnt[i] != '0) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
    assign active[i] = (cnt[i] != '0);
  end

  always_comb begin
    top = 2'd0;
    if (active[3]) begin
      top = 2'd3;
    end else if (active[2]) begin
      top = 2'd2;
    end else if (active[1]) begin
      top = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 2'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    unique case (state)
      IDLE: begin
        if (|active) begin
          state_nxt = PLAY;
          owner_nxt = top;
        end
      end
      PLAY: begin
        if (!(|active)) begin
          state_nxt = IDLE;
        end else if (!active[owner] ||
                     (top > owner)) begin
          owner_nxt = top;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 3'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 3'd1;
    end
  end

  assign gate = (volume == 3'd7) ||
                (pwm_cnt < volume);

`ifdef AUDIO_MIXER_MUTE_EN
  assign mute_s = mute;
`else
  assign mute_s = 1'b0;
`endif

  assign spk_nxt = (state == PLAY) &&
                   wave_q[owner] &&
                   gate && !mute_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speaker_out <= 1'b0;
    end else begin
      speaker_out <= spk_nxt;
    end
  end

  assign busy      = (state == PLAY);
  assign active_ch = owner;

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have parameter ACT_WINDOW, default 100000, cycles a source stays active after its last toggle; covers the 90556-cycle longest tone half-period.
REQ-002 SHALL have parameter CNT_W, default 17, activity counter width; ACT_WINDOW < 2**CNT_W.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port win_snd  input  1  level-win tone square wave, channel 3, highest priority.
REQ-006 SHALL have port water_snd  input  1  water-collision tone square wave, channel 2.
REQ-007 SHALL have port car_snd  input  1  car-collision tone square wave, channel 1.
REQ-008 SHALL have port hop_snd  input  1  frog-hop tone square wave, channel 0, lowest priority.
REQ-009 SHALL have port volume  input  3  output level: 0 silent, 7 full.
REQ-010 SHALL have port speaker_out  output  1  mixed one-bit speaker drive.
REQ-011 SHALL have port active_ch  output  2  channel number currently owning the output.
REQ-012 SHALL have port busy  output  1  high while in state PLAY.

Function
REQ-013 SHALL register all four tone inputs each cycle into wave_q[3:0] (capture stage); inputs are synchronous to clk.
REQ-014 SHALL keep one CNT_W-bit activity counter per channel: load ACT_WINDOW when wave_q differs from its previous value, else decrement when nonzero, saturating at 0.
REQ-015 SHALL treat channel n as active when its counter is nonzero.
REQ-016 SHALL implement FSM IDLE/PLAY: IDLE->PLAY when any channel is active, owner set to the highest-priority active channel.
REQ-017 SHALL in PLAY switch owner, one cycle later, to any active channel of higher priority than the owner (preemption).
REQ-018 SHALL in PLAY, when the owner goes inactive, switch to the highest-priority remaining active channel, or return to IDLE if none.
REQ-019 SHALL never let a lower-priority channel preempt an active owner.
REQ-020 SHALL free-run a 3-bit pwm_cnt incrementing every cycle, wrapping 7->0.
REQ-021 SHALL compute gate = (volume == 7) OR (pwm_cnt < volume).
REQ-022 SHALL register speaker_out = wave_q[owner] AND gate in PLAY, 0 in IDLE; steady-state latency input->speaker_out is 2 clk edges.
REQ-023 SHALL make speaker_out first go high no earlier than edge 3 after the first toggle of an idle channel (capture, FSM, output).
REQ-024 SHALL hold active_ch at the last owner while IDLE.
REQ-025 SHALL, on simultaneous activation of several channels from IDLE, select the highest priority.
REQ-026 SHALL reload a counter on a toggle occurring the same cycle it would reach 0, keeping the channel active.

Reset
REQ-027 SHALL on rst_n low, asynchronously: state IDLE, wave_q 0, all counters 0, pwm_cnt 0, speaker_out 0, active_ch 0, busy 0.
REQ-028 SHALL abort any ongoing playback when reset asserts mid-tone; after release a source must toggle again to become active.

Configuration
REQ-029 SHALL with AUDIO_MIXER_MUTE_EN defined add port mute  input  1; while mute is high, speaker_out is registered 0 and the FSM, counters and active_ch run unchanged.
REQ-030 SHALL without AUDIO_MIXER_MUTE_EN have no mute port; speaker_out follows REQ-022 only.

Verification
REQ-031 SHALL cover: volume=7, water_snd toggling every 40337 cycles, others 0 -> busy 1, active_ch=2, speaker_out equals water_snd delayed 2 cycles.
REQ-032 SHALL cover: hop playing, win_snd starts toggling -> active_ch 0->3 one cycle after win becomes active; hop resumes (active_ch=0) after win is silent for 100000 cycles.
REQ-033 SHALL cover: water owns, car starts -> active_ch stays 2; water stops -> active_ch=1 exactly 100000+1 cycles after water's last toggle.
REQ-034 SHALL cover: volume=3, constant-high owner wave -> speaker_out high 3 of every 8 cycles; volume=0 -> speaker_out always 0.
REQ-035 SHALL cover: rst_n pulsed low mid-tone -> all outputs 0 immediately; no output until the next input toggle.
REQ-036 SHALL cover: with AUDIO_MIXER_MUTE_EN, mute=1 during playback -> speaker_out 0 from the next edge, busy and active_ch unchanged.
